clk_switch_ctrl: RTL
====================

CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
- REQ-001: Parameter SYNC_STAGES, default 2; number of synchronizer flops on sel_req_i and lock_i, legal range 2..4.
- REQ-002: Parameter RST_CYCLES, default 16; cycles that rst_req_o is held before select_o changes, legal range 1..255.
- REQ-003: Parameter SETTLE_CYCLES, default 8; cycles that rst_req_o is held after select_o changes, legal range 1..255.
- REQ-004: clk_i  in  1  single block clock, free-running reference clock (not the muxed clock).
- REQ-005: rst_i  in  1  synchronous, active-high reset.
- REQ-006: sel_req_i  in  1  requested source: 0 = clk0, 1 = clk1; asynchronous to clk_i.
- REQ-007: lock_i  in  1  clk1 PLL locked; asynchronous to clk_i.
- REQ-008: test_mode_i  in  1  scan/test override; quasi-static.
- REQ-009: err_clr_i  in  1  single-cycle clear of lock_err_o.
- REQ-010: select_o  out  1  registered select to the downstream glitch-free clock mux.
- REQ-011: rst_req_o  out  1  registered request to hold the muxed-clock domain in reset.
- REQ-012: busy_o  out  1  high while a switch sequence is in progress.
- REQ-013: done_o  out  1  one-cycle pulse when a switch sequence completes.
- REQ-014: lock_err_o  out  1  sticky flag: clk1 lost lock while selected or while a switch to it was in progress.

Function
- REQ-015: sel_req_i and lock_i shall each pass through SYNC_STAGES flops; req_s and lock_s are the synchronized values, and both reset to 0.
- REQ-016: The effective target shall be tgt = req_s AND lock_s.
- REQ-017: The FSM states shall be IDLE, PRE (reset held, old clock still selected) and POST (new clock selected, reset still held).
- REQ-018: IDLE, trigger: when test_mode_i=0 and tgt != select_o, the FSM shall latch tgt into tgt_q, load the counter with RST_CYCLES-1, and go to PRE.
- REQ-019: IDLE, no trigger: otherwise the FSM shall stay in IDLE.
- REQ-020: PRE, counting: the counter shall decrement once per cycle.
- REQ-021: PRE, counter at 0: select_o shall take the value (tgt_q AND lock_s), the counter shall load SETTLE_CYCLES-1, and the FSM shall go to POST.
- REQ-022: POST: the counter shall decrement once per cycle; at 0 the FSM shall go to IDLE and pulse done_o for one cycle.
- REQ-023: rst_req_o and busy_o shall be 1 exactly while the state is PRE or POST.
- REQ-024: Cycle-level latency: input edge at cycle 0 → tgt visible at cycle SYNC_STAGES → PRE entered (rst_req_o=1) at cycle SYNC_STAGES+1 → select_o changes at SYNC_STAGES+1+RST_CYCLES → rst_req_o=0 with done_o=1 at SYNC_STAGES+1+RST_CYCLES+SETTLE_CYCLES.
- REQ-025: Changes of sel_req_i during PRE or POST shall be ignored; the new request shall be re-evaluated in IDLE on the cycle after done_o.
- REQ-026: Lock lost while clk1 is selected: select_o=1 with lock_s=0 in IDLE shall start a switch to clk0 and set lock_err_o.
- REQ-027: Lock lost during a switch to clk1: if tgt_q=1 and lock_s=0 at the end of PRE, select_o shall remain 0, lock_err_o shall be set, and POST shall still run to completion.
- REQ-028: Lock lost during POST after select_o=1: the sequence shall complete, and the REQ-026 path shall then trigger from IDLE.
- REQ-029: lock_err_o shall set on any REQ-026/027 event and clear on err_clr_i=1; set shall win if both occur in the same cycle.
- REQ-030: test_mode_i=1 in IDLE shall block new sequences and leave outputs unchanged.
- REQ-031: test_mode_i=1 asserted mid-sequence shall not abort the sequence.
- REQ-032: The counter shall be 8 bits wide and shall never wrap; in IDLE it shall hold 0.

Reset
- REQ-033: With rst_i=1 at a clock edge: state=IDLE, select_o=0, rst_req_o=0, busy_o=0, done_o=0, lock_err_o=0, counter=0, tgt_q=0, all synchronizer flops=0.
- REQ-034: Reset asserted mid-sequence shall abort the sequence immediately, with select_o=0 and rst_req_o=0 on the following cycle.
- REQ-035: After reset is released, a pending sel_req_i=1 with lock_i=1 shall start a new sequence after SYNC_STAGES+1 cycles.

Verification
- REQ-036: Defaults, lock_i=1, sel_req_i 0→1 at cycle 0 → rst_req_o=1 at cycle 3, select_o=1 at cycle 19, rst_req_o=0 and done_o=1 at cycle 27.
- REQ-037: lock_i=0, sel_req_i=1 → no sequence starts and all outputs stay at 0.
- REQ-038: Settled on clk1, lock_i drops → a switch sequence starts 3 cycles later, select_o returns to 0 after a further 16 cycles, lock_err_o=1, and err_clr_i clears it.
- REQ-039: sel_req_i toggled 1→0 during PRE → the sequence completes with select_o=1, then a second sequence returns select_o to 0.
- REQ-040: test_mode_i=1 with a request pending → no sequence starts; on test_mode_i falling, the sequence starts on the next cycle.
- REQ-041: rst_i pulsed in POST → all outputs return to their reset values the following cycle.

Source files
------------

// File: rtl/clk_switch_ctrl.sv
// Clock-source switch sequencer: holds the muxed-clock domain in reset around a
// change of the glitch-free mux select, and falls back to clk0 when clk1 loses lock.
module clk_switch_ctrl #(
   parameter int SYNC_STAGES   = 2,
   parameter int RST_CYCLES    = 16,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sel_req_i,
   input  logic lock_i,
   input  logic test_mode_i,
   input  logic err_clr_i,
   output logic select_o,
   output logic rst_req_o,
   output logic busy_o,
   output logic done_o,
   output logic lock_err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      POST = 2'd2
   } state_e;

   localparam logic [7:0] RST_LOAD    = 8'(RST_CYCLES - 1);
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] req_sync_q;
   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic                   req_s;
   logic                   lock_s;
   logic                   tgt_s;
   logic                   trigger_s;
   logic                   err_set_s;
   logic                   lock_err_d;

   state_e     state_q;
   logic [7:0] cnt_q;
   logic       tgt_q;
   logic       select_q;
   logic       rst_req_q;
   logic       busy_q;
   logic       done_q;
   logic       lock_err_q;

   // Bring the asynchronous request and lock inputs into the clk_i domain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_sync_q  <= '0;
         lock_sync_q <= '0;
      end else begin
         req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], sel_req_i};
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], lock_i};
      end
   end

   assign req_s = req_sync_q[SYNC_STAGES-1];
   assign lock_s = lock_sync_q[SYNC_STAGES-1];
   assign tgt_s = req_s & lock_s;

   // Sequence start condition and lock-error events.
   always_comb begin
      trigger_s = 1'b0;
      err_set_s = 1'b0;
      case (state_q)
         IDLE: begin
            trigger_s = !test_mode_i && (tgt_s != select_q);
            err_set_s = trigger_s && select_q && !lock_s;
         end
         PRE: begin
            err_set_s = (cnt_q == 8'd0) && tgt_q && !lock_s;
         end
         default: begin
            err_set_s = 1'b0;
         end
      endcase
   end

   // A set event in the same cycle as a clear keeps the flag raised.
   assign lock_err_d = err_set_s | (lock_err_q & ~err_clr_i);

   // Switch sequencer with registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         tgt_q      <= 1'b0;
         select_q   <= 1'b0;
         rst_req_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         lock_err_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         lock_err_q <= lock_err_d;
         case (state_q)
            IDLE: begin
               if (trigger_s) begin
                  tgt_q     <= tgt_s;
                  cnt_q     <= RST_LOAD;
                  rst_req_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= PRE;
               end else begin
                  cnt_q <= 8'd0;
               end
            end
            PRE: begin
               if (cnt_q == 8'd0) begin
                  // Never hand the mux a clk1 that is not locked.
                  select_q <= tgt_q & lock_s;
                  cnt_q    <= SETTLE_LOAD;
                  state_q  <= POST;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            POST: begin
               if (cnt_q == 8'd0) begin
                  rst_req_q <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            default: begin
               cnt_q     <= 8'd0;
               rst_req_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign select_o   = select_q;
   assign rst_req_o  = rst_req_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign lock_err_o = lock_err_q;

endmodule
